// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar counters: BCD widths, month codes and day counts.
package clock_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0]   bcd_t;
  typedef logic [2*BCD_W-1:0] bcd2_t;

  // Months are stored as a packed two-digit BCD value {tens, units}
  localparam bcd2_t JAN = 8'h01;
  localparam bcd2_t FEB = 8'h02;
  localparam bcd2_t MAR = 8'h03;
  localparam bcd2_t APR = 8'h04;
  localparam bcd2_t MAY = 8'h05;
  localparam bcd2_t JUN = 8'h06;
  localparam bcd2_t JUL = 8'h07;
  localparam bcd2_t AUG = 8'h08;
  localparam bcd2_t SEP = 8'h09;
  localparam bcd2_t OCT = 8'h10;
  localparam bcd2_t NOV = 8'h11;
  localparam bcd2_t DEC = 8'h12;

  localparam logic [4:0] DAYS_28 = 5'd28;
  localparam logic [4:0] DAYS_29 = 5'd29;
  localparam logic [4:0] DAYS_30 = 5'd30;
  localparam logic [4:0] DAYS_31 = 5'd31;

  // A BCD pair is a multiple of 4 iff an even tens digit meets 0/4/8 or an odd one meets 2/6
  function automatic logic bcd_div4(input bcd_t tens, input bcd_t units);
    if (tens[0])
      return (units == 4'd2) || (units == 4'd6);
    else
      return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction
endpackage

// File: rtl/counter_months_if.sv
// Month counter bus: mode/adjust/carry inputs and year digits in, month digits, day count and year carry out.
interface counter_months_if;
  import clock_pkg::*;

  logic       mode_month;
  logic       up;
  logic       down;
  logic       tick_month;
  bcd_t       year_unit;
  bcd_t       year_ten;
  bcd_t       year_hundred;
  bcd_t       year_thousand;
  bcd_t       month_unit;
  bcd_t       month_ten;
  logic [4:0] max_days;
  logic       tick_year;

  modport master (
    output mode_month, up, down, tick_month,
    output year_unit, year_ten, year_hundred, year_thousand,
    input  month_unit, month_ten, max_days, tick_year
  );

  modport slave (
    input  mode_month, up, down, tick_month,
    input  year_unit, year_ten, year_hundred, year_thousand,
    output month_unit, month_ten, max_days, tick_year
  );
endinterface

// File: rtl/leap_year_detect.sv
// Gregorian leap-year test on a four-digit BCD year, evaluated digit-wise with no binary conversion.
module leap_year_detect
  import clock_pkg::*;
(
  input  bcd_t year_unit,
  input  bcd_t year_ten,
  input  bcd_t year_hundred,
  input  bcd_t year_thousand,
  output logic leap
);

  logic div4_low;
  logic div4_high;
  logic century;

  // On a century year the low pair is 00, so divisibility by 400 reduces to the high pair being a multiple of 4
  always_comb begin
    div4_low  = bcd_div4(year_ten, year_unit);
    div4_high = bcd_div4(year_thousand, year_hundred);
    century   = (year_ten == 4'd0) && (year_unit == 4'd0);
    leap      = div4_low && (!century || div4_high);
  end

endmodule

// File: rtl/counter_months.sv
// BCD month counter (01..12): advances on day carries in run mode, steps on up/down edges in set mode.
module counter_months
  import clock_pkg::*;
#(
  parameter int RESET_MONTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_months_if.slave  bus
);

  localparam bcd_t RST_TEN  = bcd_t'(RESET_MONTH / 10);
  localparam bcd_t RST_UNIT = bcd_t'(RESET_MONTH % 10);

  bcd2_t month_q;
  bcd2_t month_d;
  bcd2_t month_inc;
  bcd2_t month_dec;
  logic  up_q;
  logic  down_q;
  logic  up_rise;
  logic  down_rise;
  logic  tick_year_q;
  logic  tick_year_d;
  logic  leap;

  // BCD neighbours of the current month, including the digit carry at 09/10 and the 12/01 wrap
  always_comb begin
    if (month_q == DEC)
      month_inc = JAN;
    else if (month_q[3:0] == 4'd9)
      month_inc = OCT;
    else
      month_inc = month_q + 8'd1;

    if (month_q == JAN)
      month_dec = DEC;
    else if (month_q == OCT)
      month_dec = SEP;
    else
      month_dec = month_q - 8'd1;
  end

  always_comb begin
    month_d     = month_q;
    tick_year_d = 1'b0;
    up_rise     = bus.up && !up_q;
    down_rise   = bus.down && !down_q;
    if (bus.mode_month) begin
      if (bus.tick_month) begin
        month_d     = month_inc;
        tick_year_d = (month_q == DEC);
      end
    end else if (up_rise && !down_rise) begin
      month_d = month_inc;
    end else if (down_rise && !up_rise) begin
      month_d = month_dec;
    end
  end

  // Edge history updates in both modes so a level held across a mode switch never steps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      month_q     <= {RST_TEN, RST_UNIT};
      tick_year_q <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
    end else begin
      month_q     <= month_d;
      tick_year_q <= tick_year_d;
      up_q        <= bus.up;
      down_q      <= bus.down;
    end
  end

  leap_year_detect u_leap (
    .year_unit     (bus.year_unit),
    .year_ten      (bus.year_ten),
    .year_hundred  (bus.year_hundred),
    .year_thousand (bus.year_thousand),
    .leap          (leap)
  );

  always_comb begin
    case (month_q)
      APR, JUN, SEP, NOV: bus.max_days = DAYS_30;
      FEB:                bus.max_days = leap ? DAYS_29 : DAYS_28;
      default:            bus.max_days = DAYS_31;
    endcase
  end

  assign bus.month_ten  = month_q[7:4];
  assign bus.month_unit = month_q[3:0];
  assign bus.tick_year  = tick_year_q;

endmodule

// File: tb/tb_counter_months.sv
// Directed self-checking bench for counter_months: run-mode wrap, leap years, set-mode edges and reset priority.
module tb_counter_months;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  int   daysNonLeap [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  counter_months_if bus ();

  counter_months #(.RESET_MONTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int m);
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [7:0] monthNow();
    return {bus.month_ten, bus.month_unit};
  endfunction

  task automatic applyStimulus(input logic mode, input logic upIn, input logic downIn, input logic tick);
    bus.mode_month = mode;
    bus.up         = upIn;
    bus.down       = downIn;
    bus.tick_month = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setYear(input int y);
    bus.year_thousand = 4'((y / 1000) % 10);
    bus.year_hundred  = 4'((y / 100) % 10);
    bus.year_ten      = 4'((y / 10) % 10);
    bus.year_unit     = 4'(y % 10);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkMonth(input string tag, input logic [7:0] expMonth, input logic expTickYear);
    checkOutput({tag, " month"}, monthNow(), expMonth);
    checkOutput({tag, " tick_year"}, {7'd0, bus.tick_year}, {7'd0, expTickYear});
  endtask

  task automatic pulseUp(input string tag, input logic [7:0] expMonth);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkMonth(tag, expMonth, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseDown(input string tag, input logic [7:0] expMonth);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkMonth(tag, expMonth, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    bus.mode_month = 1'b1;
    bus.up         = 1'b0;
    bus.down       = 1'b0;
    bus.tick_month = 1'b0;
    setYear(2024);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkMonth("reset", 8'h01, 1'b0);
    checkOutput("reset max_days", {3'd0, bus.max_days}, 8'd31);
    rst_n = 1'b1;

    // Twelve consecutive carries: 02..12 then the wrap to 01 raises tick_year for one cycle
    for (int i = 2; i <= 13; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkMonth($sformatf("run step %0d", i), (i == 13) ? 8'h01 : toBcd(i), i == 13);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkMonth("run idle after wrap", 8'h01, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkMonth("run to feb", 8'h02, 1'b0);
    setYear(2024);
    checkOutput("feb 2024", {3'd0, bus.max_days}, 8'd29);
    setYear(2100);
    checkOutput("feb 2100", {3'd0, bus.max_days}, 8'd28);
    setYear(2000);
    checkOutput("feb 2000", {3'd0, bus.max_days}, 8'd29);
    setYear(1900);
    checkOutput("feb 1900", {3'd0, bus.max_days}, 8'd28);
    setYear(1996);
    checkOutput("feb 1996", {3'd0, bus.max_days}, 8'd29);
    setYear(2023);
    checkOutput("feb 2023", {3'd0, bus.max_days}, 8'd28);

    for (int m = 3; m <= 12; m++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkMonth($sformatf("run to %0d", m), toBcd(m), 1'b0);
      checkOutput($sformatf("days month %0d", m), {3'd0, bus.max_days}, 8'(daysNonLeap[m-1]));
    end

    // Set mode: up wraps 12 to 01 without a year carry
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkMonth("set idle", 8'h12, 1'b0);
    pulseUp("set up wrap", 8'h01);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkMonth("up held first", 8'h02, 1'b0);
    for (int i = 1; i < 36; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkMonth("up held 36", 8'h02, 1'b0);
    for (int i = 0; i < 36; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkMonth("down held 36", 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulseDown("down wrap", 8'h12);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkMonth("up and down together", 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkMonth("set tick ignored 1", 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkMonth("set tick ignored 2", 8'h12, 1'b0);

    pulseDown("down to 11", 8'h11);
    pulseDown("down to 10", 8'h10);
    pulseDown("down to 09", 8'h09);
    pulseUp("up to 10", 8'h10);
    pulseUp("up to 11", 8'h11);
    pulseUp("up to 12", 8'h12);

    // A level raised in run mode is history by the time set mode is entered
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkMonth("run up ignored", 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkMonth("up high on entry", 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkMonth("reset over tick", 8'h01, 1'b0);
    checkOutput("reset over tick max_days", {3'd0, bus.max_days}, 8'd31);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkMonth("after reset", 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/counter_months.md
COUNTER_MONTHS -- requirements
Module: counter_months

Interface
REQ-001 Parameter: RESET_MONTH, default 1, month loaded on reset (legal range 1..12).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 mode_month  input  1  1 = run mode (tick_month advances), 0 = set mode (up/down adjust).
REQ-005 up  input  1  set-mode increment request, level; rising edge acts.
REQ-006 down  input  1  set-mode decrement request, level; rising edge acts.
REQ-007 tick_month  input  1  one-cycle carry from the day counter.
REQ-008 year_unit, year_ten, year_hundred, year_thousand  input  4 each  current year, BCD digits.
REQ-009 month_unit  output  4  month ones digit, BCD.
REQ-010 month_ten  output  4  month tens digit, BCD (0 or 1).
REQ-011 max_days  output  5  days in the current month, to the day counter.
REQ-012 tick_year  output  1  one-cycle carry to the year counter.

Function
REQ-013 Month SHALL be held as a two-digit BCD value, always in 01..12; any other value is unreachable.
REQ-014 Run mode: a cycle with tick_month=1 SHALL advance the month by one at that clock edge; 12 wraps to 01.
REQ-015 Run mode: on the 12->01 wrap from tick_month, tick_year SHALL be 1 for exactly the next cycle; otherwise 0.
REQ-016 Run mode: up and down SHALL be ignored.
REQ-017 Set mode: tick_month SHALL be ignored and tick_year SHALL stay 0.
REQ-018 Set mode: a rising edge on up (up=1, previous-cycle up=0) SHALL increment by one; 12 wraps to 01, no tick_year.
REQ-019 Set mode: a rising edge on down SHALL decrement by one; 01 wraps to 12.
REQ-020 Set mode: simultaneous rising edges on up and down SHALL leave the month unchanged; holding up or down high SHALL not repeat a step.
REQ-021 The previous-cycle up/down registers SHALL update every cycle in both modes, so a level already high on entry to set mode produces no step.
REQ-022 Month update latency: one clock from the sampled event; tick_year registered, same edge as the month wrap.
REQ-023 max_days SHALL be combinational from the registered month and the year inputs: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if leap, else 28.
REQ-024 Leap rule (Gregorian): year divisible by 4 and (not by 100, or by 400); evaluated on BCD digits without binary conversion.
REQ-025 Divisibility by 4 of a BCD pair (T,U): T even and U in {0,4,8}, or T odd and U in {2,6}.
REQ-026 Year inputs are trusted BCD; no range checking.
REQ-027 Mode changes take effect on the same cycle that mode_month is sampled; no pending events are carried across.

Reset
REQ-028 While rst_n=0 at a clock edge: month = RESET_MONTH (default 01), tick_year = 0, edge registers = 0; all other inputs ignored.
REQ-029 Reset asserted mid-operation SHALL override any simultaneous tick_month, up or down on that edge.
REQ-030 After reset with default, max_days = 31.

Structure
REQ-031 The shared package clock_pkg SHALL hold the BCD digit width, month constants (JAN..DEC) and day-count constants (28/29/30/31).
REQ-032 Leap-year evaluation SHALL be a sub-module leap_year_detect (four BCD digit inputs, one leap output), reusable by the year counter.

Verification
REQ-033 Reset, run mode, tick_month high 12 cycles -> months 02..12,01; tick_year=1 only the cycle after 12->01.
REQ-034 Year 2024 then 2100 then 2000, month forced to 02 -> max_days 29, 28, 29; months 04/09 -> 30; 07/08 -> 31.
REQ-035 Set mode, month 01, up held high 36 cycles -> month 02 only; down held 36 cycles -> back to 01; one more down pulse -> 12.
REQ-036 Set mode, up and down rising together -> month unchanged; tick_month pulses in set mode -> no change, tick_year stays 0.
REQ-037 rst_n low for one edge coincident with tick_month at month 12 -> month 01, tick_year stays 0.
